pulse_timestamper: RTL
======================

# pulse_timestamper

Receiving end of the pulse path: samples the asynchronous toggle-level event line, where each level transition marks one event, into the `clk` domain. Each event is tagged with a free-running coarse-time counter value, and the tags are buffered in a small FIFO that drains over a valid/ready interface. Overflow is reported through a sticky flag and a saturating drop counter. It sits between the delay-line/pulse front end and the tag readout logic.

## Interface
- `COUNTER_WIDTH`, 16: coarse counter and tag width.
- `SYNC_STAGES`, 2: synchronizer flops on `toggle_in`; legal values ≥ 2.
- `FIFO_DEPTH`, 4: tag FIFO entries; power of two, ≥ 2.
- `DROP_WIDTH`, 8: drop counter width.
- `clk` input 1: single clock; all flops on its rising edge.
- `rst_n` input 1: one clock; reset is asynchronous and active-low.
- `toggle_in` input 1: asynchronous event line; every transition is one event.
- `clear` input 1: synchronous clear of `overflow` and `drop_count`.
- `tag_data` output COUNTER_WIDTH: timestamp at FIFO head.
- `tag_valid` output 1: FIFO not empty.
- `tag_ready` input 1: consumer accepts head when high together with `tag_valid`.
- `overflow` output 1: sticky, set when an event is dropped.
- `drop_count` output DROP_WIDTH: saturating count of dropped events.

## Operation
- Synchronizer: `toggle_in` passes through SYNC_STAGES flops. Register `prev` follows the last stage every edge. `evt` = last stage XOR `prev`.
- Coarse counter: resets to 0 and increments every edge. It wraps modulo 2^COUNTER_WIDTH with no flag.
- Startup arming: writes are suppressed at the first SYNC_STAGES+1 edges after `rst_n` rises.
  - The level sampled at the first edge is taken as the initial line state, not an event.
  - A line held at 1 through reset produces no tag.
- Write: at an edge where `evt`=1, armed, and the FIFO is not full, the current counter value is pushed. This is the value held during the cycle before that edge.
- Drop: at an edge where `evt`=1, armed, and the FIFO is full:
  - the event is discarded;
  - `overflow` is set to 1;
  - `drop_count` increments, saturating at all-ones.
- Full is the pre-edge state. A simultaneous pop does not rescue a write into a full FIFO; that event is dropped.
- Read: at an edge with `tag_valid`=1 and `tag_ready`=1 the head is popped.
  - `tag_data` is undefined-but-stable while `tag_valid`=0. It must not change while `tag_valid`=1 and `tag_ready`=0.
- Simultaneous write and read on a non-full, non-empty FIFO: both occur and occupancy is unchanged.
- Write into an empty FIFO: `tag_valid` rises the following cycle. There is no read on that edge because `tag_valid` was low.
- `clear`: on the edge where it is high, `overflow`→0 and `drop_count`→0. If a drop occurs on the same edge, the drop wins: `overflow`=1, `drop_count`=1.
- Input rule: transitions on `toggle_in` must be ≥ 2 clk periods apart. Closer transitions may merge, and an even number of merged transitions yields no event. This is not an error condition.
- FIFO storage: circular buffer with log2(FIFO_DEPTH)+1-bit pointers (wrap bit distinguishes full from empty). The pointer extra bit toggles on wrap.

## Timing
- Reset (async, `rst_n`=0):
  - synchronizer, `prev`, counter, pointers and arming state → 0;
  - `tag_valid`=0, `overflow`=0, `drop_count`=0;
  - FIFO emptied.
  - This applies mid-operation too: buffered tags are lost and no partial state survives.
- Latency: a transition first sampled at edge n is written at edge n+SYNC_STAGES. `tag_valid` is high from just after that edge. Its tag equals n+SYNC_STAGES−1 modulo 2^COUNTER_WIDTH, with edges numbered from 1 after reset release.
- Sustained throughput: one tag per clock in and out. The input rule limits input to one event per 2 clocks.
- `overflow` and `drop_count` update on the drop edge.

## Test plan
- Single event (defaults): `toggle_in` 0→1 before edge 5, consumer ready → exactly one tag, `tag_data`=6, `tag_valid` high after edge 7, drop_count=0.
- Startup level: `toggle_in`=1 through reset and held → no tag ever; a later 1→0 sampled at edge 10 → tag 11.
- Overflow: `tag_ready`=0, five events spaced 3 cycles → four tags retained in order, `overflow`=1, `drop_count`=1.
  - Then `clear` → both 0.
  - Then drain → four ascending tags, `tag_valid`=0.
- Full with simultaneous pop: FIFO full, event write edge coincides with a pop → event dropped, `drop_count` increments, occupancy becomes 3.
- Wrap and saturation (COUNTER_WIDTH=4, DROP_WIDTH=2):
  - event sampled at edge 15 → tag 0;
  - 5 drops → `drop_count`=3.
- Reset mid-operation: 3 tags buffered, `rst_n` pulsed low → `tag_valid`=0 immediately, counter restarts, next event sampled at edge 4 → tag 5.

Source files
------------

// File: rtl/pulse_timestamper.sv
// Samples an asynchronous toggle-level event line, tags each event with a
// free-running coarse counter and queues the tags in a small FIFO.
module pulse_timestamper #(
  parameter int unsigned COUNTER_WIDTH = 16,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned DROP_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     toggle_in,
  input  logic                     clear,
  output logic [COUNTER_WIDTH-1:0] tag_data,
  output logic                     tag_valid,
  input  logic                     tag_ready,
  output logic                     overflow,
  output logic [DROP_WIDTH-1:0]    drop_count
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned ARM_EDGES = SYNC_STAGES + 1;
  localparam int unsigned ARM_W     = $clog2(ARM_EDGES + 1);

  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic                     prev_q;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [ARM_W-1:0]         arm_q, arm_d;
  logic [AW:0]              wr_q, wr_d, rd_q, rd_d;
  logic                     ovf_q, ovf_d;
  logic [DROP_WIDTH-1:0]    drop_q, drop_d;
  logic [COUNTER_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic evt, armed, full, empty, push, drop, pop;

  assign evt   = sync_q[SYNC_STAGES-1] ^ prev_q;
  assign armed = (arm_q == ARM_W'(ARM_EDGES));
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push  = evt && armed && !full;
  assign drop  = evt && armed && full;
  assign pop   = !empty && tag_ready;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], toggle_in};
    cnt_d  = cnt_q + COUNTER_WIDTH'(1);
    arm_d  = armed ? arm_q : arm_q + ARM_W'(1);
    wr_d   = push ? wr_q + (AW+1)'(1) : wr_q;
    rd_d   = pop  ? rd_q + (AW+1)'(1) : rd_q;
    ovf_d  = ovf_q;
    drop_d = drop_q;
    // A drop on the same edge as clear restarts the count at one.
    if (drop) begin
      ovf_d = 1'b1;
      if (clear)
        drop_d = DROP_WIDTH'(1);
      else if (drop_q != '1)
        drop_d = drop_q + DROP_WIDTH'(1);
    end else if (clear) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
      arm_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[SYNC_STAGES-1];
      cnt_q  <= cnt_d;
      arm_q  <= arm_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_q[AW-1:0]] <= cnt_q;
  end

  assign tag_data   = mem_q[rd_q[AW-1:0]];
  assign tag_valid  = !empty;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule
